// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT Hadamard-stage scheduler:
// FSM state encoding, geometry helpers and the in-flight tracker entry.
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_NEXT  = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam int unsigned N_POINTS_DEF = 64;
  localparam int unsigned RD_LAT_DEF   = 1;
  localparam int unsigned PIPE_LAT_DEF = 5;

  // Tracker tag fields are sized for the largest supported transform
  // (up to 1024 points); narrower configurations zero-extend into them.
  localparam int unsigned TRK_GRP_W = 8;
  localparam int unsigned TRK_STG_W = 4;

  // Groups per stage: G = N / 4
  function automatic int unsigned grp_count(input int unsigned n);
    return n / 4;
  endfunction

  // Stages per transform: S = log4(N)
  function automatic int unsigned stage_count(input int unsigned n);
    int unsigned m;
    int unsigned s;
    m = n;
    s = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (m > 1) begin
        m = m / 4;
        s = s + 1;
      end
    end
    return s;
  endfunction

  // Tracker depth: buffer/ROM read latency plus datapath latency
  function automatic int unsigned tracker_depth(input int unsigned rd_lat,
                                                input int unsigned pipe_lat);
    return rd_lat + pipe_lat;
  endfunction

  localparam int unsigned G = grp_count(N_POINTS_DEF);
  localparam int unsigned S = stage_count(N_POINTS_DEF);
  localparam int unsigned D = tracker_depth(RD_LAT_DEF, PIPE_LAT_DEF);

  typedef struct packed {
    logic                 valid;
    logic [TRK_GRP_W-1:0] grp;
    logic [TRK_STG_W-1:0] stage;
  } trk_entry_t;

endpackage

// File: rtl/hadamard_stage_sched_if.sv
// Handshake/bus bundle between the Hadamard-stage scheduler and its
// surroundings. Optional macro HSCHED_PERF_EN adds the stall_cnt field.
interface hadamard_stage_sched_if #(
  parameter int unsigned GRP_W = 4,
  parameter int unsigned STG_W = 2
);

  logic                   start;
  logic                   hold;
  logic                   busy;
  logic                   done;
  logic                   rd_en;
  logic [GRP_W-1:0]       rd_grp;
  logic [STG_W+GRP_W-1:0] tw_addr;
  logic [STG_W-1:0]       stage;
  logic                   wr_en;
  logic [GRP_W-1:0]       wr_grp;
  logic [STG_W-1:0]       wr_stage;
`ifdef HSCHED_PERF_EN
  logic [15:0]            stall_cnt;
`endif

  modport master (
    input  start, hold,
    output busy, done, rd_en, rd_grp, tw_addr, stage, wr_en, wr_grp, wr_stage
`ifdef HSCHED_PERF_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output start, hold,
    input  busy, done, rd_en, rd_grp, tw_addr, stage, wr_en, wr_grp, wr_stage
`ifdef HSCHED_PERF_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/hadamard_stage_sched_tracker.sv
// hsched_tracker: fixed-depth delay line of {valid, grp, stage} tags that
// follows each issued group through the non-stallable datapath.
module hsched_tracker
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned GRP_W = 4,
  parameter int unsigned STG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  trk_entry_t       push,
  output logic             tail_valid,
  output logic [GRP_W-1:0] tail_grp,
  output logic [STG_W-1:0] tail_stage,
  output logic             empty
);

  trk_entry_t sh_q [DEPTH];
  trk_entry_t sh_d [DEPTH];
  logic       any_valid;

  // Next shift-register contents: new tag enters at the head every cycle
  always_comb begin
    sh_d[0] = push;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sh_d[i] = sh_q[i-1];
    end
  end

  // Shift register; cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sh_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

  // Pipeline occupancy: empty once no stored tag is valid
  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | sh_q[i].valid;
    end
  end

  assign empty      = ~any_valid;
  assign tail_valid = sh_q[DEPTH-1].valid;
  assign tail_grp   = sh_q[DEPTH-1].grp[GRP_W-1:0];
  assign tail_stage = sh_q[DEPTH-1].stage[STG_W-1:0];

endmodule

// File: rtl/hadamard_stage_sched.sv
// hadamard_stage_sched: walks every stage and 4-point group of a radix-4
// FFT, issues buffer/twiddle reads, and produces write-back strobes aligned
// with the fixed-latency Hadamard datapath. The pipeline is drained at each
// stage boundary. Optional macro HSCHED_PERF_EN adds a hold-stall counter.
module hadamard_stage_sched
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 64,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned PIPE_LAT = 5,
  parameter int unsigned GRP_W    = 4,
  parameter int unsigned STG_W    = 2
) (
  input logic                   clk,
  input logic                   rst,
  hadamard_stage_sched_if.master bus
);

  localparam int unsigned NG = grp_count(N_POINTS);
  localparam int unsigned NS = stage_count(N_POINTS);
  localparam int unsigned ND = tracker_depth(RD_LAT, PIPE_LAT);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NG - 1);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NS - 1);

  state_t           state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic             issue;
  logic             busy;
  logic             done;
  trk_entry_t       push_entry;
  logic             trk_empty;
  logic             trk_valid;
  logic [GRP_W-1:0] trk_grp;
  logic [STG_W-1:0] trk_stage;

  // Next-state, counter and strobe logic
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    stage_d = stage_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          grp_d   = '0;
          stage_d = '0;
        end
      end
      ST_ISSUE: begin
        busy = 1'b1;
        if (!bus.hold) begin
          issue = 1'b1;
          // grp parks at G-1 after the last issue; only NEXT rewinds it
          if (grp_q == LAST_GRP) begin
            state_d = ST_DRAIN;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (trk_empty) begin
          state_d = (stage_q == LAST_STG) ? ST_FIN : ST_NEXT;
        end
      end
      ST_NEXT: begin
        busy    = 1'b1;
        stage_d = stage_q + 1'b1;
        grp_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      stage_q <= stage_d;
    end
  end

  // Tag pushed into the tracker; idle slots carry an all-zero entry
  always_comb begin
    push_entry = '0;
    if (issue) begin
      push_entry.valid = 1'b1;
      push_entry.grp   = TRK_GRP_W'(grp_q);
      push_entry.stage = TRK_STG_W'(stage_q);
    end
  end

  hsched_tracker #(
    .DEPTH (ND),
    .GRP_W (GRP_W),
    .STG_W (STG_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .push       (push_entry),
    .tail_valid (trk_valid),
    .tail_grp   (trk_grp),
    .tail_stage (trk_stage),
    .empty      (trk_empty)
  );

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.rd_en    = issue;
  assign bus.rd_grp   = grp_q;
  assign bus.tw_addr  = {stage_q, grp_q};
  assign bus.stage    = stage_q;
  assign bus.wr_en    = trk_valid;
  assign bus.wr_grp   = trk_grp;
  assign bus.wr_stage = trk_stage;

`ifdef HSCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Stall counter: cleared on start acceptance, counts held ISSUE cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && bus.start) begin
      stall_cnt_d = '0;
    end else if (state_q == ST_ISSUE && bus.hold && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hadamard_stage_sched.sv
// Self-checking bench for hadamard_stage_sched (N=16 and N=64 instances),
// random hold patterns checked against a schedule model built from the
// stage/group sequencing rules.
module tb_hadamard_stage_sched;

  localparam int MAXC = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hadamard_stage_sched_if #(.GRP_W(2), .STG_W(1)) b16 ();
  hadamard_stage_sched_if #(.GRP_W(4), .STG_W(2)) b64 ();

  hadamard_stage_sched #(
    .N_POINTS (16), .RD_LAT (1), .PIPE_LAT (5), .GRP_W (2), .STG_W (1)
  ) u_dut16 (.clk (clk), .rst (rst), .bus (b16));

  hadamard_stage_sched #(
    .N_POINTS (64), .RD_LAT (1), .PIPE_LAT (5), .GRP_W (4), .STG_W (2)
  ) u_dut64 (.clk (clk), .rst (rst), .bus (b64));

  bit   big = 1'b0;
  logic start_s = 1'b0;
  logic hold_s  = 1'b0;

  assign b16.start = big ? 1'b0 : start_s;
  assign b16.hold  = big ? 1'b0 : hold_s;
  assign b64.start = big ? start_s : 1'b0;
  assign b64.hold  = big ? hold_s  : 1'b0;

  logic o_rd, o_wr, o_busy, o_done;
  int   o_rd_grp, o_tw, o_stage, o_wr_grp, o_wr_stage;
`ifdef HSCHED_PERF_EN
  int   o_stall;
`endif

  always_comb begin
    if (big) begin
      o_rd = b64.rd_en; o_wr = b64.wr_en; o_busy = b64.busy; o_done = b64.done;
      o_rd_grp = int'(b64.rd_grp); o_tw = int'(b64.tw_addr); o_stage = int'(b64.stage);
      o_wr_grp = int'(b64.wr_grp); o_wr_stage = int'(b64.wr_stage);
    end else begin
      o_rd = b16.rd_en; o_wr = b16.wr_en; o_busy = b16.busy; o_done = b16.done;
      o_rd_grp = int'(b16.rd_grp); o_tw = int'(b16.tw_addr); o_stage = int'(b16.stage);
      o_wr_grp = int'(b16.wr_grp); o_wr_stage = int'(b16.wr_stage);
    end
  end
`ifdef HSCHED_PERF_EN
  assign o_stall = big ? int'(b64.stall_cnt) : int'(b16.stall_cnt);
`endif

  int errors = 0;
  int checks = 0;

  // configuration and model
  int cg, cs, cd;
  bit h_arr [MAXC];
  bit m_rd  [MAXC];
  int m_grp [MAXC];
  int m_stg [MAXC];
  bit m_wr  [MAXC];
  int m_wgrp[MAXC];
  int m_wstg[MAXC];
  int m_done, m_stalls;

  // observations from the last transform
  int obs_done;
  int wcnt     [4];
  int last_wr  [4];
  int first_rd [4];

  task automatic set_cfg(input bit b);
    big = b;
    cg  = b ? 16 : 4;
    cs  = b ? 3 : 2;
    cd  = 6;
  endtask

  // Schedule model: each stage reads groups 0..G-1 on the non-held cycles;
  // the stage ends once its last result has been written back (D cycles
  // after its read) plus one cycle to observe the empty pipeline, then one
  // boundary cycle before the next stage or the done pulse.
  function automatic void build_model();
    int t, last, g;
    for (int i = 0; i < MAXC; i++) begin
      m_rd[i] = 0; m_grp[i] = 0; m_stg[i] = 0;
      m_wr[i] = 0; m_wgrp[i] = 0; m_wstg[i] = 0;
    end
    t = 0; last = 0; m_stalls = 0; m_done = MAXC - 1;
    for (int s = 0; s < cs; s++) begin
      g = 0;
      while (g < cg && t < MAXC) begin
        if (h_arr[t]) begin
          m_stalls++;
        end else begin
          m_rd[t] = 1; m_grp[t] = g; m_stg[t] = s; last = t; g++;
        end
        t++;
      end
      t = last + cd + 2;
      if (s < cs - 1) t = t + 1;
      else m_done = t;
    end
    for (int i = 0; i < MAXC; i++) begin
      if (i >= cd && m_rd[i-cd]) begin
        m_wr[i] = 1; m_wgrp[i] = m_grp[i-cd]; m_wstg[i] = m_stg[i-cd];
      end
    end
  endfunction

  task automatic clear_hold();
    for (int i = 0; i < MAXC; i++) h_arr[i] = 0;
  endtask

  task automatic rand_hold(input int pct);
    for (int i = 0; i < MAXC; i++) h_arr[i] = ($urandom_range(0, 99) < pct);
  endtask

  // Runs one transform from IDLE, entered and left right after a rising edge.
  task automatic run_xfer(input bit extra_start, input bit start_hold);
    obs_done = -1;
    for (int s = 0; s < 4; s++) begin
      wcnt[s] = 0; last_wr[s] = -1; first_rd[s] = -1;
    end
    build_model();
    start_s = 1'b1;
    hold_s  = start_hold;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int t = 0; t < MAXC; t++) begin
      hold_s  = h_arr[t];
      start_s = (extra_start && t == 5);
      @(negedge clk);
      checks++;
      if (o_rd !== m_rd[t]) begin
        errors++; $display("FAIL rd_en t=%0d got=%0b exp=%0b", t, o_rd, m_rd[t]);
      end
      if (m_rd[t]) begin
        checks++;
        if (o_rd_grp !== m_grp[t] || o_stage !== m_stg[t] || o_tw !== m_stg[t] * cg + m_grp[t]) begin
          errors++;
          $display("FAIL rd_tag t=%0d got grp=%0d stg=%0d tw=%0d exp grp=%0d stg=%0d tw=%0d",
                   t, o_rd_grp, o_stage, o_tw, m_grp[t], m_stg[t], m_stg[t] * cg + m_grp[t]);
        end
      end
      checks++;
      if (o_wr !== m_wr[t]) begin
        errors++; $display("FAIL wr_en t=%0d got=%0b exp=%0b", t, o_wr, m_wr[t]);
      end
      if (m_wr[t]) begin
        checks++;
        if (o_wr_grp !== m_wgrp[t] || o_wr_stage !== m_wstg[t]) begin
          errors++;
          $display("FAIL wr_tag t=%0d got grp=%0d stg=%0d exp grp=%0d stg=%0d",
                   t, o_wr_grp, o_wr_stage, m_wgrp[t], m_wstg[t]);
        end
      end
      checks++;
      if (o_busy !== (t < m_done) || o_done !== (t == m_done)) begin
        errors++;
        $display("FAIL busy_done t=%0d got busy=%0b done=%0b exp busy=%0b done=%0b",
                 t, o_busy, o_done, (t < m_done), (t == m_done));
      end
      if (o_done === 1'b1 && obs_done < 0) obs_done = t;
      if (o_wr === 1'b1 && o_wr_stage < 4) begin
        wcnt[o_wr_stage]++;
        last_wr[o_wr_stage] = t;
      end
      if (o_rd === 1'b1 && o_stage < 4 && first_rd[o_stage] < 0) first_rd[o_stage] = t;
`ifdef HSCHED_PERF_EN
      if (t == m_done) begin
        checks++;
        if (o_stall !== m_stalls) begin
          errors++; $display("FAIL stall_cnt got=%0d exp=%0d", o_stall, m_stalls);
        end
      end
`endif
      if (t == m_done) break;
      @(posedge clk); #1;
    end
    start_s = 1'b0;
    hold_s  = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < cs; s++) begin
      checks++;
      if (wcnt[s] !== cg) begin
        errors++; $display("FAIL wr_count stage=%0d got=%0d exp=%0d", s, wcnt[s], cg);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (o_rd !== 1'b0 || o_wr !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_rd_grp !== 0 || o_tw !== 0 || o_stage !== 0 || o_wr_grp !== 0 || o_wr_stage !== 0) begin
      errors++;
      $display("FAIL %s got rd=%0b wr=%0b busy=%0b done=%0b rg=%0d tw=%0d st=%0d wg=%0d ws=%0d exp all 0",
               name, o_rd, o_wr, o_busy, o_done, o_rd_grp, o_tw, o_stage, o_wr_grp, o_wr_stage);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_cfg(0); @(negedge clk); check_all_zero("reset16");
      set_cfg(1); #0; check_all_zero("reset64");
    end
    set_cfg(0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    set_cfg(0); clear_hold();
    run_xfer(1'b0, 1'b0);
    checks++;
    if (obs_done !== 23) begin
      errors++; $display("FAIL nominal_done got=%0d exp=23", obs_done);
    end
  endtask

  task automatic test_backpressure();
    set_cfg(0); clear_hold();
    h_arr[1] = 1; h_arr[2] = 1;
    run_xfer(1'b0, 1'b0);
    checks++;
    if (obs_done !== 25) begin
      errors++; $display("FAIL hold_done got=%0d exp=25", obs_done);
    end
  endtask

  task automatic test_ignored_start();
    set_cfg(0); clear_hold();
    run_xfer(1'b1, 1'b1);
    checks++;
    if (obs_done !== 23) begin
      errors++; $display("FAIL ignored_start_done got=%0d exp=23", obs_done);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      set_cfg(k[0]);
      rand_hold(30);
      run_xfer($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_stage_boundary();
    for (int k = 0; k < 2; k++) begin
      set_cfg(1);
      if (k == 0) clear_hold(); else rand_hold(25);
      run_xfer(1'b0, 1'b0);
      for (int s = 1; s < cs; s++) begin
        checks++;
        if (!(first_rd[s] > last_wr[s-1]) || first_rd[s] < 0) begin
          errors++;
          $display("FAIL boundary stage=%0d first_rd=%0d last_wr_prev=%0d", s, first_rd[s], last_wr[s-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    set_cfg(0); clear_hold();
    run_xfer(1'b0, 1'b0);
    d1 = obs_done;
    run_xfer(1'b0, 1'b0);
    checks++;
    if (obs_done !== d1 || obs_done !== 23) begin
      errors++; $display("FAIL back_to_back_done got=%0d first=%0d exp=23", obs_done, d1);
    end
  endtask

  task automatic test_mid_reset();
    set_cfg(0); clear_hold();
    build_model();
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      checks++;
      if (o_rd !== m_rd[t]) begin
        errors++; $display("FAIL pre_reset_rd t=%0d got=%0b exp=%0b", t, o_rd, m_rd[t]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("mid_reset");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (o_wr !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_rd !== 1'b0) begin
        errors++;
        $display("FAIL after_reset i=%0d got wr=%0b done=%0b busy=%0b rd=%0b exp 0", i, o_wr, o_done, o_busy, o_rd);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_ignored_start();
    test_random();
    test_stage_boundary();
    test_back_to_back();
    test_mid_reset();
    test_nominal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
